// File: rtl/pkt_enq_framer.sv
// pkt_enq_framer
// Store-and-forward framer in front of the packet processor. Buffers one
// complete upstream packet to learn its length, then replays it on the
// processor enqueue interface. Oversize packets are discarded.
//
// Ports:
//   pck_proc_int_mem_fsm_clk    clock
//   pck_proc_int_mem_fsm_sw_rst synchronous active-high reset
//   s_valid/s_ready/s_data/s_last  upstream word stream with end-of-packet
//   enq_req, in_sop, in_eop, wr_data_i  enqueue word strobe and framing
//   pck_len_valid, pck_len_i    packet length, qualified with in_sop
//   pck_proc_full               processor full: stalls replay
//   pck_proc_almost_full        processor almost full: holds packet start
//   busy                        framer not idle
//   pkt_sent_cnt, pkt_drop_cnt  wrapping statistics counters
module pkt_enq_framer #(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 12,
  parameter int MAX_WORDS = 64,
  parameter int CNT_W     = 16
) (
  input  logic              pck_proc_int_mem_fsm_clk,
  input  logic              pck_proc_int_mem_fsm_sw_rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              enq_req,
  output logic              in_sop,
  output logic              in_eop,
  output logic [DATA_W-1:0] wr_data_i,
  output logic              pck_len_valid,
  output logic [LEN_W-1:0]  pck_len_i,
  input  logic              pck_proc_full,
  input  logic              pck_proc_almost_full,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_sent_cnt,
  output logic [CNT_W-1:0]  pkt_drop_cnt
);

  localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WAIT_ROOM, S_SEND, S_DROP
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               enq_req_q, enq_req_d;
  logic               in_sop_q, in_sop_d;
  logic               in_eop_q, in_eop_d;
  logic               len_vld_q, len_vld_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [LEN_W-1:0]   pck_len_q, pck_len_d;

  logic [DATA_W-1:0]  mem_q [MAX_WORDS];
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic               accept;

  assign s_ready = (state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_DROP);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    len_d     = len_q;
    sent_d    = sent_q;
    drop_d    = drop_q;
    // Enqueue strobes and data are single-cycle; only the length holds.
    enq_req_d = 1'b0;
    in_sop_d  = 1'b0;
    in_eop_d  = 1'b0;
    len_vld_d = 1'b0;
    wdata_d   = '0;
    pck_len_d = pck_len_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q[AW-1:0];

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wr_ptr_d  = ONE;
          if (s_last) begin
            len_d   = ONE;
            state_d = S_WAIT_ROOM;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (accept) begin
          if (wr_ptr_q == MAX_LEN) begin
            // Buffer already full: this packet cannot be replayed.
            wr_ptr_d = '0;
            if (s_last) begin
              drop_d  = drop_q + 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_DROP;
            end
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
            if (s_last) begin
              len_d   = wr_ptr_q + ONE;
              state_d = S_WAIT_ROOM;
            end
          end
        end
      end
      S_WAIT_ROOM: begin
        if (!pck_proc_full && !pck_proc_almost_full) begin
          enq_req_d = 1'b1;
          in_sop_d  = 1'b1;
          len_vld_d = 1'b1;
          pck_len_d = len_q;
          in_eop_d  = (len_q == ONE);
          wdata_d   = mem_q[0];
          rd_ptr_d  = ONE;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        // rd_ptr == len means the word now on the outputs is the last one;
        // it is committed regardless of full.
        if (rd_ptr_q == len_q) begin
          sent_d   = sent_q + 1'b1;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          state_d  = S_IDLE;
        end else if (!pck_proc_full) begin
          enq_req_d = 1'b1;
          wdata_d   = mem_q[rd_ptr_q[AW-1:0]];
          in_eop_d  = ((rd_ptr_q + ONE) == len_q);
          rd_ptr_d  = rd_ptr_q + ONE;
        end
      end
      S_DROP: begin
        if (accept && s_last) begin
          drop_d   = drop_q + 1'b1;
          wr_ptr_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (pck_proc_int_mem_fsm_sw_rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      len_q     <= '0;
      sent_q    <= '0;
      drop_q    <= '0;
      enq_req_q <= 1'b0;
      in_sop_q  <= 1'b0;
      in_eop_q  <= 1'b0;
      len_vld_q <= 1'b0;
      wdata_q   <= '0;
      pck_len_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      len_q     <= len_d;
      sent_q    <= sent_d;
      drop_q    <= drop_d;
      enq_req_q <= enq_req_d;
      in_sop_q  <= in_sop_d;
      in_eop_q  <= in_eop_d;
      len_vld_q <= len_vld_d;
      wdata_q   <= wdata_d;
      pck_len_q <= pck_len_d;
    end
  end

  // Packet storage carries no reset; pointers decide what is valid.
  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (mem_we) mem_q[mem_waddr] <= s_data;
  end

  assign enq_req       = enq_req_q;
  assign in_sop        = in_sop_q;
  assign in_eop        = in_eop_q;
  assign pck_len_valid = len_vld_q;
  assign wr_data_i     = wdata_q;
  assign pck_len_i     = pck_len_q;
  assign busy          = (state_q != S_IDLE);
  assign pkt_sent_cnt  = sent_q;
  assign pkt_drop_cnt  = drop_q;

endmodule

// File: tb/tb_pkt_enq_framer.sv
module tb_pkt_enq_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        enq_req, in_sop, in_eop, pck_len_valid;
  logic [31:0] wr_data_i;
  logic [11:0] pck_len_i;
  logic        full = 1'b0;
  logic        afull = 1'b0;
  logic        busy;
  logic [15:0] sent_cnt, drop_cnt;

  pkt_enq_framer #(.DATA_W(32), .LEN_W(12), .MAX_WORDS(64), .CNT_W(16)) dut (
    .pck_proc_int_mem_fsm_clk(clk),
    .pck_proc_int_mem_fsm_sw_rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .enq_req(enq_req),
    .in_sop(in_sop),
    .in_eop(in_eop),
    .wr_data_i(wr_data_i),
    .pck_len_valid(pck_len_valid),
    .pck_len_i(pck_len_i),
    .pck_proc_full(full),
    .pck_proc_almost_full(afull),
    .busy(busy),
    .pkt_sent_cnt(sent_cnt),
    .pkt_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [11:0] len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_enq = 0;
  int   sop_cyc = -1;
  int   eop_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every enqueued word is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (enq_req) begin
        n_enq++;
        if (in_sop) sop_cyc = cyc;
        if (in_eop) eop_cyc = cyc;
        chk("sb_avail", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("data", 64'(wr_data_i), 64'(e.d));
          chk("sop", 64'(in_sop), 64'(e.sop));
          chk("eop", 64'(in_eop), 64'(e.eop));
          chk("len_valid", 64'(pck_len_valid), 64'(e.sop));
          if (e.sop) chk("pck_len", 64'(pck_len_i), 64'(e.len));
        end
      end else begin
        chk("idle_zero", 64'({in_sop, in_eop, pck_len_valid, wr_data_i}), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int len, input logic [31:0] base, input bit push,
                          output int t_last, output int stalls);
    int n;
    stalls = 0;
    t_last = 0;
    for (int i = 0; i < len; i++) begin
      s_valid = 1'b1;
      s_data  = base + 32'(i);
      s_last  = (i == len - 1);
      n = 0;
      while (!s_ready && n < 100) begin
        step();
        n++;
        stalls++;
      end
      if (n >= 100) chk("ready_timeout", 64'(s_ready), 64'd1);
      if (push) sb.push_back('{d: base + 32'(i), sop: (i == 0), eop: (i == len - 1), len: 12'(len)});
      t_last = cyc;
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    int t, st, e0, n;

    // Reset state
    repeat (3) step();
    chk("rst_enq_req", 64'(enq_req), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_counters", 64'({sent_cnt, drop_cnt}), 64'd0);
    chk("rst_pck_len", 64'(pck_len_i), 64'd0);
    rst = 1'b0;
    step();

    // 4-word packet, no backpressure
    sop_cyc = -1; eop_cyc = -1; e0 = n_enq;
    send_pkt(4, 32'hA0, 1'b1, t, st);
    chk("t1_ready_drop", 64'(s_ready), 64'd0);
    wait_idle();
    chk("t1_sop_cyc", 64'(sop_cyc), 64'(t + 2));
    chk("t1_eop_cyc", 64'(eop_cyc), 64'(t + 5));
    chk("t1_count", 64'(n_enq - e0), 64'd4);
    chk("t1_sent", 64'(sent_cnt), 64'd1);
    chk("t1_ready_back", 64'(s_ready), 64'd1);

    // 1-word packet
    sop_cyc = -1; eop_cyc = -1; e0 = n_enq;
    send_pkt(1, 32'hB0, 1'b1, t, st);
    wait_idle();
    chk("t2_sop_cyc", 64'(sop_cyc), 64'(t + 2));
    chk("t2_eop_cyc", 64'(eop_cyc), 64'(t + 2));
    chk("t2_count", 64'(n_enq - e0), 64'd1);
    chk("t2_sent", 64'(sent_cnt), 64'd2);

    // almost_full holds the packet start
    afull = 1'b1;
    sop_cyc = -1; e0 = n_enq;
    send_pkt(3, 32'hC0, 1'b1, t, st);
    for (int i = 0; i < 10; i++) begin
      chk("t3_ready_low", 64'(s_ready), 64'd0);
      chk("t3_no_enq", 64'(enq_req), 64'd0);
      step();
    end
    afull = 1'b0;
    n = cyc;
    wait_idle();
    chk("t3_sop_cyc", 64'(sop_cyc), 64'(n + 1));
    chk("t3_count", 64'(n_enq - e0), 64'd3);
    chk("t3_len_hold", 64'({pck_len_valid, pck_len_i}), 64'd3);

    // full pulse mid-packet
    sop_cyc = -1; eop_cyc = -1; e0 = n_enq;
    send_pkt(6, 32'hD0, 1'b1, t, st);
    step(); step(); step();
    full = 1'b1;
    step();
    chk("t4_stall_enq", 64'(enq_req), 64'd0);
    step(); step();
    full = 1'b0;
    wait_idle();
    chk("t4_sop_cyc", 64'(sop_cyc), 64'(t + 2));
    chk("t4_eop_cyc", 64'(eop_cyc), 64'(t + 10));
    chk("t4_count", 64'(n_enq - e0), 64'd6);
    chk("t4_sent", 64'(sent_cnt), 64'd4);

    // Oversize packets: 65 and 66 words
    e0 = n_enq;
    send_pkt(65, 32'h1000, 1'b0, t, st);
    chk("t5_stalls65", 64'(st), 64'd0);
    chk("t5_ready_after", 64'(s_ready), 64'd1);
    chk("t5_drop1", 64'(drop_cnt), 64'd1);
    send_pkt(66, 32'h2000, 1'b0, t, st);
    chk("t5_stalls66", 64'(st), 64'd0);
    repeat (3) step();
    chk("t5_drop2", 64'(drop_cnt), 64'd2);
    chk("t5_no_enq", 64'(n_enq - e0), 64'd0);
    sop_cyc = -1;
    send_pkt(2, 32'hE0, 1'b1, t, st);
    wait_idle();
    chk("t5_next_sop", 64'(sop_cyc), 64'(t + 2));
    chk("t5_sent", 64'(sent_cnt), 64'd5);

    // Reset while the third of five words is on the outputs
    eop_cyc = -1;
    send_pkt(5, 32'hF0, 1'b1, t, st);
    step(); step(); step();
    @(negedge clk);
    #1;
    rst = 1'b1;
    step();
    chk("t6_enq_req", 64'(enq_req), 64'd0);
    chk("t6_s_ready", 64'(s_ready), 64'd1);
    chk("t6_counters", 64'({sent_cnt, drop_cnt}), 64'd0);
    chk("t6_no_eop", 64'(eop_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_pending", 64'(sb.size()), 64'd2);
    sb.delete();
    rst = 1'b0;
    step();
    sop_cyc = -1; eop_cyc = -1; e0 = n_enq;
    send_pkt(3, 32'h300, 1'b1, t, st);
    wait_idle();
    chk("t6_sop_cyc", 64'(sop_cyc), 64'(t + 2));
    chk("t6_eop_cyc", 64'(eop_cyc), 64'(t + 4));
    chk("t6_count", 64'(n_enq - e0), 64'd3);
    chk("t6_sent", 64'(sent_cnt), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_enq_framer.md
# pkt_enq_framer

Store-and-forward framer placed directly upstream of the packet processor. It accepts a valid/ready word stream with an end-of-packet marker and buffers one complete packet to learn its length. It then replays the packet on the processor's enqueue interface: enq_req, in_sop, in_eop, wr_data_i, and pck_len_valid with pck_len_i. Replay is throttled by the processor's full and almost-full status, and oversize packets are dropped before they reach the processor.

## Interface
- DATA_W, 32, word width; must match wr_data_i.
- LEN_W, 12, width of pck_len_i.
- MAX_WORDS, 64, buffer depth in words, which is also the largest packet accepted; must be ≤ 2^LEN_W−1.
- CNT_W, 16, width of the statistics counters.

Ports:
- pck_proc_int_mem_fsm_clk, in, 1, the single clock.
- pck_proc_int_mem_fsm_sw_rst, in, 1, synchronous reset, active-high.
- s_valid, in, 1, upstream word valid.
- s_ready, out, 1, framer can accept a word.
- s_data, in, DATA_W, upstream word.
- s_last, in, 1, marks the last word of a packet.
- enq_req, out, 1, enqueue strobe, one per word.
- in_sop, out, 1, first word of the packet.
- in_eop, out, 1, last word of the packet.
- wr_data_i, out, DATA_W, enqueued word.
- pck_len_valid, out, 1, length qualifier; asserted together with in_sop.
- pck_len_i, out, LEN_W, packet length in words.
- pck_proc_full, in, 1, processor full.
- pck_proc_almost_full, in, 1, processor almost full.
- busy, out, 1, high whenever the state is not IDLE.
- pkt_sent_cnt, out, CNT_W, packets enqueued; wraps.
- pkt_drop_cnt, out, CNT_W, oversize packets dropped; wraps.

## Operation
- States: IDLE, FILL, WAIT_ROOM, SEND, DROP.
- Buffer: flop array of MAX_WORDS entries, with write pointer wr_ptr and read pointer rd_ptr.
- A word is accepted on a cycle where s_valid and s_ready are both high.
- s_ready is high in IDLE, FILL and DROP, and low in WAIT_ROOM and SEND.
- IDLE: an accepted word is written to buf[0] and wr_ptr becomes 1.
  - If s_last is also high, go to WAIT_ROOM with len=1.
  - Otherwise go to FILL.
- FILL: each accepted word is written to buf[wr_ptr] and wr_ptr increments.
  - On s_last, go to WAIT_ROOM with len=wr_ptr+1.
  - If a word is accepted with wr_ptr==MAX_WORDS and s_last low, go to DROP. The word is not written.
- DROP: accept and discard words until a word with s_last is accepted.
  - Then pkt_drop_cnt increments, wr_ptr clears, and the state returns to IDLE.
  - Nothing is enqueued for a dropped packet.
- WAIT_ROOM: when pck_proc_full==0 and pck_proc_almost_full==0, go to SEND and load word 0.
- SEND: one word is enqueued per cycle while pck_proc_full==0.
  - When full is high, the framer stalls.
  - After the last word, pkt_sent_cnt increments and the state returns to IDLE.
- First word: in_sop=1, pck_len_valid=1, pck_len_i=len.
- Last word: in_eop=1. A one-word packet has in_sop, in_eop and pck_len_valid all high in the same cycle.
- pck_len_i holds its value until the next pck_len_valid. All other enqueue outputs are 0 whenever enq_req=0.
- Length arithmetic: len is a LEN_W-bit count of words and is never 0.
- Reset values:
  - All outputs 0, except s_ready=1.
  - State IDLE; pointers 0; counters 0.
- Reset mid-packet: a partially buffered or partially sent packet is abandoned. No in_eop is emitted for it.

## Timing
- All enqueue-side outputs are registered.
- WAIT_ROOM to SEND:
  - Room is sampled in cycle N.
  - The edge at the end of N loads word 0.
  - enq_req/in_sop are visible during cycle N+1.
- Throughput: one word per cycle in SEND while full stays low. An L-word packet occupies L cycles of enq_req.
- Stall:
  - pck_proc_full is sampled every cycle.
  - If full is high in cycle K, enq_req is 0 in cycle K+1 and rd_ptr holds.
  - The word presented in cycle K is already committed; one word can land at the processor while it is full.
  - Sending resumes the cycle after full is sampled low, with in_sop/in_eop framing preserved.
- almost_full gates only the start of a packet. It is ignored once SEND has begun.
- Input-to-output latency for an L-word packet with no backpressure:
  - The last input word is accepted in cycle T.
  - WAIT_ROOM is cycle T+1.
  - First enq_req is cycle T+2; in_eop is cycle T+L+1.
- s_ready drops in the cycle after the s_last word is accepted.
- s_ready returns high in the cycle after the in_eop word is presented.

## Test plan
- Reset, then a 4-word packet A0..A3 with no backpressure: enq_req high for 4 consecutive cycles starting 2 cycles after s_last; in_sop+pck_len_valid with pck_len_i=4 on A0; in_eop on A3; pkt_sent_cnt=1.
- A 1-word packet: a single enq_req cycle with in_sop=in_eop=pck_len_valid=1 and pck_len_i=1.
- almost_full held high for 10 cycles after a packet is buffered: no enq_req until the cycle after almost_full is sampled low, and s_ready stays 0 throughout.
- pck_proc_full pulsed for 3 cycles in the middle of a 6-word packet: enq_req drops the cycle after full rises, with no word lost or duplicated; words still arrive in order and in_eop lands on word 6.
- A 65-word packet with MAX_WORDS=64: no enq_req at all, pkt_drop_cnt=1, s_ready stays high through the last word. A following 2-word packet then sends normally.
- Sync reset asserted during SEND of word 3 of 5: the next cycle has enq_req=0 and s_ready=1, both counters are 0, and a new packet after reset is framed correctly.
